// File: rtl/ifetch_unit_pkg.sv
// ifetch_unit_pkg: shared vectors, slot layout and address helper for the fetch stage
package ifetch_unit_pkg;
  localparam logic [31:0] RESET = 32'h8000_0000;
  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] XADR = 32'h8000_0008;
  localparam int SUPERVISOR_BIT = 31;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic filled;
    logic fault;
  } slot_t;
  function automatic logic [31:0] imem_word_addr(input logic [31:0] pc);
    return {1'b0, pc[SUPERVISOR_BIT-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: imem request/response bus and decode valid/ready handoff
interface ifetch_unit_if;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_gnt;
  logic imem_rvalid;
  logic [31:0] imem_rdata;
  logic imem_err;
  logic dec_valid;
  logic dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic dec_fault;
  modport master (
    output imem_req, imem_addr, dec_valid, dec_inst, dec_pc, dec_fault,
    input imem_gnt, imem_rvalid, imem_rdata, imem_err, dec_ready
  );
  modport slave (
    input imem_req, imem_addr, dec_valid, dec_inst, dec_pc, dec_fault,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err, dec_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order slot storage with head/fill/tail pointers and flush
module ifetch_queue
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic [31:0] push_pc,
  input  logic fill,
  input  logic [31:0] fill_inst,
  input  logic fill_fault,
  input  logic pop,
  input  logic flush,
  input  logic keep_head,
  output logic [PTR_W:0] count,
  output logic [PTR_W:0] unfilled,
  output slot_t head_slot
);
  localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);
  slot_t slots [DEPTH];
  logic [PTR_W:0] head, fill_p, tail, head_nx, flush_to;
  logic keep;
  // pointers carry one extra wrap bit so full and empty stay distinguishable
  assign count = tail - head;
  assign unfilled = tail - fill_p;
  assign head_slot = slots[head[PTR_W-1:0]];
  assign head_nx = head + (PTR_W+1)'(pop);
  assign keep = keep_head & ~pop & (count != '0) & (unfilled != count);
  assign flush_to = head_nx + (PTR_W+1)'(keep);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slots <= '{default: '0};
      head <= '0;
      fill_p <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= head_nx;
      tail <= flush_to;
      fill_p <= flush_to;
    end else begin
      if (push) begin
        slots[tail[PTR_W-1:0]] <= '{inst: '0, pc: push_pc, filled: 1'b0, fault: 1'b0};
        tail <= tail + ONE;
      end
      if (fill) begin
        slots[fill_p[PTR_W-1:0]].inst <= fill_inst;
        slots[fill_p[PTR_W-1:0]].filled <= 1'b1;
        slots[fill_p[PTR_W-1:0]].fault <= fill_fault;
        fill_p <= fill_p + ONE;
      end
      head <= head_nx;
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage with request gating, response dropping and redirect flush
// IFETCH_FAULT_EN: capture imem_err per slot and present it as dec_fault with a zeroed instruction
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic [31:0] fetch_pc,
  input  logic redirect,
  output logic pc_advance,
  ifetch_unit_if.master bus
);
  localparam int DROP_W = PTR_W + 4;
  logic [PTR_W:0] count, unfilled;
  slot_t head;
  logic [DROP_W-1:0] drop_cnt;
  logic accept, pop, has_unf, rsp_ok, fill_now, head_byp, fill_fault, rsp_legal;
  assign bus.imem_req = reset & ~redirect & ~count[PTR_W];
  assign bus.imem_addr = reset ? imem_word_addr(fetch_pc) : '0;
  assign accept = bus.imem_req & bus.imem_gnt;
  assign pc_advance = accept & ~redirect;
  assign has_unf = unfilled != '0;
  assign rsp_ok = bus.imem_rvalid & (drop_cnt == '0) & has_unf;
  assign rsp_legal = bus.imem_rvalid & ((drop_cnt != '0) | has_unf);
  assign fill_now = rsp_ok & ~redirect;
`ifdef IFETCH_FAULT_EN
  assign fill_fault = bus.imem_err;
`else
  assign fill_fault = 1'b0;
`endif
  // a response landing on an unfilled head is forwarded so zero-wait memory costs one cycle
  assign head_byp = rsp_ok & (unfilled == count);
  assign bus.dec_valid = (count != '0) & (head.filled | head_byp);
  assign bus.dec_fault = head.filled ? head.fault : head_byp & fill_fault;
  assign bus.dec_inst = bus.dec_fault ? '0 : (head.filled | ~head_byp) ? head.inst : bus.imem_rdata;
  assign bus.dec_pc = head.pc;
  assign pop = bus.dec_valid & bus.dec_ready;
  ifetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_queue (
    .clock(clock),
    .reset(reset),
    .push(accept),
    .push_pc(fetch_pc),
    .fill(fill_now),
    .fill_inst(bus.imem_rdata),
    .fill_fault(fill_fault),
    .pop(pop),
    .flush(redirect),
    .keep_head(1'b0),
    .count(count),
    .unfilled(unfilled),
    .head_slot(head)
  );
  // responses still owed for flushed slots, including ones owed from earlier redirects
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) drop_cnt <= '0;
    else if (redirect) drop_cnt <= drop_cnt + DROP_W'(unfilled) - DROP_W'(rsp_legal);
    else if (bus.imem_rvalid & (drop_cnt != '0)) drop_cnt <= drop_cnt - DROP_W'(1);
  end
  rsp_expected: assert property (@(posedge clock) disable iff (!reset) bus.imem_rvalid |-> (drop_cnt != '0) || has_unf)
    else $error("imem response with nothing outstanding");
endmodule
